// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment source scheduler.
package seg_pkg;

  localparam int N_SRC = 4;

  typedef logic [1:0] src_t;

  localparam src_t URG_SRC = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW_RR,
    ST_SHOW_URG
  } state_t;

  // Result of a round-robin search: whether any source 1..3 requested, and which.
  typedef struct packed {
    logic valid;
    src_t idx;
  } pick_t;

endpackage

// File: rtl/seg_src_sched_if.sv
// Request/data/display bundle between the value sources and the scheduler.
interface seg_src_sched_if;
  import seg_pkg::*;

  logic [N_SRC-1:0]    req;
  logic [32*N_SRC-1:0] data;
  logic [31:0]         disp_value;
  src_t                disp_src;
  logic                disp_active;
  logic [7:0]          blank;
  logic [N_SRC-1:0]    done;

  modport master (
    output req, data,
    input  disp_value, disp_src, disp_active, blank, done
  );

  modport slave (
    input  req, data,
    output disp_value, disp_src, disp_active, blank, done
  );

endinterface

// File: rtl/seg_tick_counter.sv
// Modulo-MOD tick counter with synchronous clear, enable and terminal-count flag.
module seg_tick_counter #(
  parameter int MOD = 4
) (
  input  logic SEG_CLK,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int W = (MOD > 1) ? $clog2(MOD) : 1;
  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge SEG_CLK or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/seg_src_sched.sv
// Time-shares the 8-digit display between an urgent source 0 and round-robin sources 1..3.
// Define SEG_SRC_SCHED_BLINK_EN to blink the display while the urgent source is shown.
module seg_src_sched
  import seg_pkg::*;
#(
  parameter int DWELL      = 1000,
  parameter int BLINK_HALF = 250
) (
  input  logic SEG_CLK,
  input  logic reset,
  seg_src_sched_if.slave bus
);

  if (DWELL < 2) begin : g_dwell_range
    $error("seg_src_sched: DWELL must be >= 2");
  end
  if (BLINK_HALF < 1) begin : g_blink_range
    $error("seg_src_sched: BLINK_HALF must be >= 1");
  end

  // First requesting source after 'last', scanning 1..3 with wrap; 'last' itself comes last.
  function automatic pick_t pick_rr(input logic [N_SRC-1:0] req, input src_t last);
    pick_t p;
    src_t  idx;
    p.valid = 1'b0;
    p.idx   = last;
    idx     = last;
    for (int k = 0; k < N_SRC - 1; k++) begin
      idx = (idx == 2'd3) ? 2'd1 : idx + 2'd1;
      if (!p.valid && req[idx]) begin
        p.valid = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

  state_t           r_state, w_state_nxt;
  src_t             r_cur, w_cur_nxt;
  src_t             r_rr_last, w_rr_last_nxt;
  logic [N_SRC-1:0] w_done_nxt;
  logic             w_dwell_en, w_dwell_tc;
  pick_t            w_pick, w_pick_exp;
  logic [7:0]       w_blank_nxt;

  logic [31:0]      r_value;
  logic             r_active;
  logic [7:0]       r_blank;
  logic [N_SRC-1:0] r_done;

  assign w_pick     = pick_rr(bus.req, r_rr_last);
  assign w_pick_exp = pick_rr(bus.req, r_cur);

  // NOTE: every combinational output is given a default first, so no latch can be inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_cur_nxt     = r_cur;
    w_rr_last_nxt = r_rr_last;
    w_done_nxt    = '0;
    w_dwell_en    = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_SHOW_URG: begin
        if (bus.req[URG_SRC]) begin
          w_state_nxt = ST_SHOW_URG;
          w_cur_nxt   = URG_SRC;
        end else if (w_pick.valid) begin
          w_state_nxt = ST_SHOW_RR;
          w_cur_nxt   = w_pick.idx;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHOW_RR: begin
        if (bus.req[URG_SRC]) begin
          w_state_nxt = ST_SHOW_URG;
          w_cur_nxt   = URG_SRC;
        end else if (!bus.req[r_cur]) begin
          // Source withdrew before its dwell ended: not credited, no done.
          w_state_nxt = w_pick.valid ? ST_SHOW_RR : ST_IDLE;
          if (w_pick.valid) w_cur_nxt = w_pick.idx;
        end else begin
          w_dwell_en = 1'b1;
          if (w_dwell_tc) begin
            w_done_nxt[r_cur] = 1'b1;
            w_rr_last_nxt     = r_cur;
            w_cur_nxt         = w_pick_exp.idx;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Counter clears whenever the current dwell is not continuing, and wraps on expiry.
  seg_tick_counter #(.MOD(DWELL)) u_dwell (
    .SEG_CLK (SEG_CLK),
    .reset   (reset),
    .i_clr   (!w_dwell_en),
    .i_en    (w_dwell_en),
    .o_tc    (w_dwell_tc)
  );

`ifdef SEG_SRC_SCHED_BLINK_EN
  logic r_blink_off, w_blink_off_nxt, w_blink_en, w_blink_tc;

  assign w_blink_en = (r_state == ST_SHOW_URG) && (w_state_nxt == ST_SHOW_URG);

  seg_tick_counter #(.MOD(BLINK_HALF)) u_blink (
    .SEG_CLK (SEG_CLK),
    .reset   (reset),
    .i_clr   (!w_blink_en),
    .i_en    (w_blink_en),
    .o_tc    (w_blink_tc)
  );

  // Entry into the urgent state always starts in the visible phase.
  assign w_blink_off_nxt = w_blink_en & (r_blink_off ^ w_blink_tc);

  always_ff @(posedge SEG_CLK or negedge reset) begin
    if (!reset) r_blink_off <= 1'b0;
    else        r_blink_off <= w_blink_off_nxt;
  end

  assign w_blank_nxt = ((w_state_nxt == ST_IDLE) || w_blink_off_nxt) ? 8'hFF : 8'h00;
`else
  assign w_blank_nxt = (w_state_nxt == ST_IDLE) ? 8'hFF : 8'h00;
`endif

  always_ff @(posedge SEG_CLK or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cur     <= URG_SRC;
      r_rr_last <= 2'd3;
      r_value   <= '0;
      r_active  <= 1'b0;
      r_blank   <= 8'hFF;
      r_done    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur     <= w_cur_nxt;
      r_rr_last <= w_rr_last_nxt;
      r_active  <= (w_state_nxt != ST_IDLE);
      r_blank   <= w_blank_nxt;
      r_done    <= w_done_nxt;
      if (w_state_nxt != ST_IDLE) r_value <= bus.data[{w_cur_nxt, 5'd0} +: 32];
    end
  end

  assign bus.disp_value  = r_value;
  assign bus.disp_src    = r_cur;
  assign bus.disp_active = r_active;
  assign bus.blank       = r_blank;
  assign bus.done        = r_done;

endmodule

// File: tb/tb_seg_src_sched.sv
// Scoreboard bench for seg_src_sched: directed stimulus pushes expectations, a monitor compares each cycle.
module tb_seg_src_sched;
  import seg_pkg::*;

  localparam int DWELL      = 4;
  localparam int BLINK_HALF = 2;

  typedef struct packed {
    logic [31:0] val;
    src_t        src;
    logic        act;
    logic [7:0]  blank;
    logic [3:0]  done;
  } exp_t;

  localparam exp_t RST_EXP = '{val: 32'h0, src: 2'd0, act: 1'b0, blank: 8'hFF, done: 4'h0};

  logic SEG_CLK = 1'b0;
  logic reset   = 1'b0;

  seg_src_sched_if bus ();

  seg_src_sched #(.DWELL(DWELL), .BLINK_HALF(BLINK_HALF)) dut (
    .SEG_CLK (SEG_CLK),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 SEG_CLK = ~SEG_CLK;

  exp_t        sb_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] dv[4];
  logic [31:0] last_val;

  function automatic exp_t sample();
    exp_t s;
    s = {bus.disp_value, bus.disp_src, bus.disp_active, bus.blank, bus.done};
    return s;
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got val=%h src=%0d act=%b blank=%h done=%b, expected val=%h src=%0d act=%b blank=%h done=%b",
               name, got.val, got.src, got.act, got.blank, got.done,
               exp.val, exp.src, exp.act, exp.blank, exp.done);
    end
  endtask

  task automatic push(input string t, input exp_t e);
    sb_q.push_back(e);
    tag_q.push_back(t);
  endtask

  // One scan tick of stimulus; the expectation is for the outputs after the next rising edge.
  task automatic step(input string t, input logic [3:0] r, input src_t s,
                      input logic act, input logic [7:0] bl, input logic [3:0] dn);
    exp_t e;
    @(negedge SEG_CLK);
    bus.req  = r;
    bus.data = {dv[3], dv[2], dv[1], dv[0]};
    if (act) last_val = dv[s];
    e = '{val: last_val, src: s, act: act, blank: bl, done: dn};
    push(t, e);
  endtask

  task automatic rr_run(input string t, input logic [3:0] r, input src_t s,
                        input logic [3:0] first_done, input int n);
    for (int i = 0; i < n; i++) begin
      step($sformatf("%s[%0d]", t, i), r, s, 1'b1, 8'h00, (i == 0) ? first_done : 4'h0);
    end
  endtask

  task automatic urg_run(input string t, input logic [3:0] r, input int n);
    logic [7:0] bl;
    for (int i = 0; i < n; i++) begin
`ifdef SEG_SRC_SCHED_BLINK_EN
      bl = (((i / BLINK_HALF) % 2) == 1) ? 8'hFF : 8'h00;
`else
      bl = 8'h00;
`endif
      step($sformatf("%s[%0d]", t, i), r, URG_SRC, 1'b1, bl, 4'h0);
    end
  endtask

  // Asserts reset between edges, checks the asynchronous effect, then releases it.
  task automatic do_reset(input string t);
    @(negedge SEG_CLK);
    reset   = 1'b0;
    bus.req = '0;
    #1 check({t, "_async"}, sample(), RST_EXP);
    push({t, "_held"}, RST_EXP);
    @(negedge SEG_CLK);
    reset = 1'b1;
    push({t, "_idle"}, RST_EXP);
    last_val = '0;
  endtask

  initial begin : monitor
    exp_t  e;
    string t;
    forever begin
      @(posedge SEG_CLK);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check(t, sample(), e);
      end
    end
  end

  initial begin : watchdog
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : stimulus
    dv[0] = 32'hE000_0BAD;
    dv[1] = 32'h1111_1111;
    dv[2] = 32'h2222_2222;
    dv[3] = 32'h3333_3333;
    last_val = '0;
    bus.req  = '0;
    bus.data = {dv[3], dv[2], dv[1], dv[0]};

    // Full rotation 1,2,3,1 with done on each switch.
    do_reset("t1_rst");
    rr_run("t1_s1", 4'b1110, 2'd1, 4'b0000, 4);
    rr_run("t1_s2", 4'b1110, 2'd2, 4'b0010, 4);
    rr_run("t1_s3", 4'b1110, 2'd3, 4'b0100, 4);
    rr_run("t1_s1b", 4'b1110, 2'd1, 4'b1000, 4);

    // Source 1 withdraws in its expiry cycle: no done; lone source 2 re-picked every dwell.
    rr_run("t2_s2", 4'b0100, 2'd2, 4'b0000, 4);
    rr_run("t2_s2b", 4'b0100, 2'd2, 4'b0100, 4);
    rr_run("t2_s2c", 4'b0100, 2'd2, 4'b0100, 4);

    // Preemption at cnt=2, then resume with rr_last unchanged; live data refresh.
    do_reset("t3_rst");
    rr_run("t3_s1", 4'b0110, 2'd1, 4'b0000, 3);
    urg_run("t3_urg", 4'b0111, 2);
    rr_run("t3_s2", 4'b0100, 2'd2, 4'b0000, 3);
    dv[2] = 32'h2BAD_C0DE;
    rr_run("t3_s2_live", 4'b0100, 2'd2, 4'b0000, 1);
    rr_run("t3_s2_exp", 4'b0100, 2'd2, 4'b0100, 2);

    // Urgent request in source 3's expiry cycle wins; no credit.
    do_reset("t4_rst");
    rr_run("t4_s3", 4'b1000, 2'd3, 4'b0000, 4);
    urg_run("t4_urg", 4'b1001, 1);
    rr_run("t4_s3b", 4'b1000, 2'd3, 4'b0000, 4);
    rr_run("t4_s3c", 4'b1000, 2'd3, 4'b1000, 1);

    // All requests drop: idle with held value and source, then reset mid-dwell.
    do_reset("t5_rst");
    rr_run("t5_s1", 4'b0010, 2'd1, 4'b0000, 2);
    dv[1] = 32'h1234_5678;
    for (int i = 0; i < 3; i++) step($sformatf("t5_idle[%0d]", i), 4'b0000, 2'd1, 1'b0, 8'hFF, 4'h0);
    rr_run("t5_s1b", 4'b0010, 2'd1, 4'b0000, 2);
    do_reset("t5_mid_rst");

    // Urgent source alone from idle; blink phase restarts after exit.
    urg_run("t6_urg", 4'b0001, 5);
    step("t6_idle", 4'b0000, URG_SRC, 1'b0, 8'hFF, 4'h0);
    urg_run("t6_urg2", 4'b0001, 3);

    repeat (3) @(negedge SEG_CLK);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
